// File: rtl/target_net_max_scheduler.sv
// Sequential max/argmax search over a buffered set of fp32 Q-values, time-sharing one
// external fp32 adder (operated as a subtractor) for the magnitude comparisons.
module target_net_max_scheduler #(
  parameter int DATA_WIDTH            = 32,
  parameter int NUMBER_OF_OUTPUT_NODE = 3,
  parameter int INDEX_WIDTH           = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic [DATA_WIDTH-1:0]  i_data,
  output logic                   o_ready,
  output logic                   o_add_valid,
  output logic [DATA_WIDTH-1:0]  o_add_a,
  output logic [DATA_WIDTH-1:0]  o_add_b,
  input  logic                   i_add_valid,
  input  logic [DATA_WIDTH-1:0]  i_add_data,
  output logic                   o_valid,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic [INDEX_WIDTH-1:0] o_index,
  output logic [2:0]             o_dbg_state
);

  // Handshake: a beat transfers on a rising clk edge where i_valid && o_ready; when
  // o_ready is low the beat is dropped, never stalled or buffered.
  localparam int DEPTH = (NUMBER_OF_OUTPUT_NODE > 1) ? NUMBER_OF_OUTPUT_NODE : 2;
  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(NUMBER_OF_OUTPUT_NODE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state_q;
  logic [DATA_WIDTH-1:0]  buf_q [DEPTH];
  logic [DATA_WIDTH-1:0]  buf_d [DEPTH];
  logic [INDEX_WIDTH-1:0] cnt_q;
  logic [INDEX_WIDTH-1:0] k_q;
  logic [INDEX_WIDTH-1:0] k_d;
  logic [DATA_WIDTH-1:0]  max_q;
  logic [DATA_WIDTH-1:0]  max_d;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [INDEX_WIDTH-1:0] idx_d;
  logic                   add_valid_q;
  logic [DATA_WIDTH-1:0]  add_a_q;
  logic [DATA_WIDTH-1:0]  add_b_q;
  logic                   valid_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic                   accept;
  logic                   cand_wins;

  function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] v);
    return {~v[DATA_WIDTH-1], v[DATA_WIDTH-2:0]};
  endfunction

  assign o_ready     = ((state_q == S_IDLE) || (state_q == S_LOAD)) && !rst;
  assign accept      = i_valid && o_ready;
  assign o_add_valid = add_valid_q;
  assign o_add_a     = add_a_q;
  assign o_add_b     = add_b_q;
  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_index     = index_q;
  assign o_dbg_state = state_q;

  // A strictly positive difference means the candidate wins; +0/-0 keeps the older index.
  assign cand_wins = !i_add_data[DATA_WIDTH-1] && (|i_add_data[DATA_WIDTH-2:0]);

  always_comb begin
    buf_d = buf_q;
    if (accept) buf_d[cnt_q] = i_data;
    k_d   = k_q + 1'b1;
    max_d = cand_wins ? buf_q[k_q] : max_q;
    idx_d = cand_wins ? k_q : idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      max_q       <= '0;
      idx_q       <= '0;
      add_valid_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      index_q     <= '0;
    end else begin
      add_valid_q <= 1'b0;
      valid_q     <= 1'b0;
      case (state_q)
        S_IDLE, S_LOAD: begin
          if (accept) begin
            buf_q <= buf_d;
            if (cnt_q == LAST) begin
              cnt_q <= '0;
              max_q <= buf_d[0];
              idx_q <= '0;
              k_q   <= INDEX_WIDTH'(1);
              if (NUMBER_OF_OUTPUT_NODE == 1) begin
                state_q <= S_DONE;
              end else begin
                // Operands are launched together with the ISSUE state so the pulse lands in it.
                state_q     <= S_ISSUE;
                add_valid_q <= 1'b1;
                add_a_q     <= buf_d[1];
                add_b_q     <= negate(buf_d[0]);
              end
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= S_LOAD;
            end
          end
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          if (i_add_valid) begin
            max_q <= max_d;
            idx_q <= idx_d;
            if (k_q == LAST) begin
              state_q <= S_DONE;
            end else begin
              k_q         <= k_d;
              state_q     <= S_ISSUE;
              add_valid_q <= 1'b1;
              add_a_q     <= buf_q[k_d];
              add_b_q     <= negate(max_d);
            end
          end
        end
        S_DONE: begin
          valid_q <= 1'b1;
          data_q  <= max_q;
          index_q <= idx_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_target_net_max_scheduler.sv
// Bench for target_net_max_scheduler: 7-cycle adder model, ordered-key reference model for
// max/argmax, expected-result queue and latency/pulse-width checks.
module tb_target_net_max_scheduler;

  localparam int DW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_ready;
  logic          o_add_valid;
  logic [DW-1:0] o_add_a;
  logic [DW-1:0] o_add_b;
  logic          i_add_valid;
  logic [DW-1:0] i_add_data;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic [IW-1:0] o_index;
  logic [2:0]    o_dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;
  logic prev_valid = 1'b0;
  logic [DW+IW-1:0] exp_q[$];

  target_net_max_scheduler #(
    .DATA_WIDTH(DW), .NUMBER_OF_OUTPUT_NODE(3), .INDEX_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
    .o_add_valid(o_add_valid), .o_add_a(o_add_a), .o_add_b(o_add_b),
    .i_add_valid(i_add_valid), .i_add_data(i_add_data),
    .o_valid(o_valid), .o_data(o_data), .o_index(o_index), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // fp32 order key: sign-magnitude mapped onto a signed integer, +0 and -0 equal.
  function automatic longint fkey(input logic [DW-1:0] v);
    longint m;
    m = longint'(v[DW-2:0]);
    return v[DW-1] ? -m : m;
  endfunction

  // ---------------- 7-cycle adder model (sign/zero faithful) ----------------
  logic [6:0]    pipe_v = '0;
  logic [DW-1:0] pipe_d [7];

  function automatic logic [DW-1:0] add_model(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint s;
    s = fkey(a) + fkey(b);
    if (s > 0) return 32'h3F80_0000;
    if (s < 0) return 32'hBF80_0000;
    return 32'h0000_0000;
  endfunction

  always @(posedge clk) begin
    pipe_v    <= {pipe_v[5:0], o_add_valid};
    pipe_d[0] <= add_model(o_add_a, o_add_b);
    for (int i = 1; i < 7; i++) pipe_d[i] <= pipe_d[i-1];
  end
  assign i_add_valid = pipe_v[6];
  assign i_add_data  = pipe_d[6];

  // ---------------- reference model ----------------
  function automatic logic [DW+IW-1:0] ref_result(input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                                                   input logic [DW-1:0] v2);
    logic [DW-1:0] v[3];
    int best;
    v[0] = v0; v[1] = v1; v[2] = v2;
    best = 0;
    for (int i = 1; i < 3; i++) if (fkey(v[i]) > fkey(v[best])) best = i;
    return {IW'(best), v[best]};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [DW+IW-1:0] e;
    if (prev_valid) check("valid_pulse", {31'b0, o_valid}, 32'd0);
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {31'b0, o_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("data", o_data, e[DW-1:0]);
        check("index", {30'b0, o_index}, {30'b0, e[DW+IW-1:DW]});
        check("latency", cyc - last_acc, 32'd17);
      end
    end
    prev_valid <= o_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic load3(input logic [DW-1:0] v0, input logic [DW-1:0] v1, input logic [DW-1:0] v2);
    logic [DW-1:0] v[3];
    int n;
    v[0] = v0; v[1] = v1; v[2] = v2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = v[i];
      n = 0;
      while (!o_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!o_ready) check("ready_timeout", {31'b0, o_ready}, 32'd1);
      @(posedge clk);
      #1;
      last_acc = cyc;
    end
    i_valid = 1'b0;
  endtask

  task automatic search(input logic [DW-1:0] v0, input logic [DW-1:0] v1, input logic [DW-1:0] v2);
    exp_q.push_back(ref_result(v0, v1, v2));
    load3(v0, v1, v2);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  function automatic logic [DW-1:0] rand_fp(input logic [DW-1:0] pool0, input logic [DW-1:0] pool1);
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 4))
      0: return pool0;
      1: return pool1;
      2: return {s, 31'h0};
      default: return {s, 8'($urandom_range(0, 254)), 23'($urandom)};
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1; i_valid = 1'b0; i_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, o_ready}, 32'd0);
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_index", {30'b0, o_index}, 32'd0);
    check("rst_add_valid", {31'b0, o_add_valid}, 32'd0);
    check("rst_add_a", o_add_a, 32'd0);
    check("rst_add_b", o_add_b, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, o_ready}, 32'd1);

    // directed patterns: ascending-middle max, negatives, ties, all equal
    search(32'h3F80_0000, 32'h4040_0000, 32'h4000_0000); wait_done();
    repeat (3) @(negedge clk);
    check("data_held", o_data, 32'h4040_0000);
    search(32'hC0A0_0000, 32'hBF80_0000, 32'hC040_0000); wait_done();
    search(32'h4000_0000, 32'h4000_0000, 32'h3F80_0000); wait_done();
    search(32'hC100_0000, 32'hC100_0000, 32'hC100_0000); wait_done();
    search(32'h0000_0000, 32'h8000_0000, 32'h8000_0000); wait_done();

    // beats during WAIT are dropped
    search(32'h3F80_0000, 32'h4040_0000, 32'h4000_0000);
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1; i_data = 32'h7F00_0000;
      check("drop_ready", {31'b0, o_ready}, 32'd0);
      @(negedge clk);
    end
    i_valid = 1'b0;
    wait_done();

    // reset during the first WAIT; the stale adder return must be ignored
    load3(32'h3F80_0000, 32'h4040_0000, 32'h4000_0000);
    n = 0;
    while (!o_add_valid && n < 20) begin @(negedge clk); n++; end
    check("issue_seen", {31'b0, o_add_valid}, 32'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", {31'b0, o_ready}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("midrst_valid", {31'b0, o_valid}, 32'd0);
      check("midrst_data", o_data, 32'd0);
      check("midrst_index", {30'b0, o_index}, 32'd0);
      @(negedge clk);
    end
    search(32'h4000_0000, 32'h3F80_0000, 32'h4080_0000); wait_done();

    // back-to-back directed, then randomized with and without gaps
    search(32'h3F80_0000, 32'h4040_0000, 32'h4000_0000);
    search(32'h4100_0000, 32'h4000_0000, 32'h4100_0000);
    wait_done();
    for (int t = 0; t < 40; t++) begin
      logic [DW-1:0] p0, p1;
      p0 = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 140)), 23'($urandom)};
      p1 = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 140)), 23'($urandom)};
      search(rand_fp(p0, p1), rand_fp(p0, p1), rand_fp(p0, p1));
      if ($urandom_range(0, 1) == 0) wait_done();
    end
    wait_done();
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
